// File: rtl/timer_bank.sv
// Bank of reload timers with a shared prescale divider and an overflow cascade chain.
// Each lane keeps its own registers; the enable/overflow ripple is resolved in the top.
module timer_lane #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock_16,
   input  logic                 reset,
   input  logic                 l_wr,
   input  logic                 h_wr,
   input  logic [15:0]          wdata,
   input  logic                 inc,
   input  logic                 ovf,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic [15:0]          ctrl,
   output logic                 start,
   output logic                 cascade,
   output logic [1:0]           presc,
   output logic                 at_max,
   output logic                 kill,
   output logic                 overflow,
   output logic                 irq
);
   logic                 irq_en;
   logic [CNT_WIDTH-1:0] reload;

   assign at_max = &cnt;
   // a stopping control write overrides any increment or overflow in the same cycle
   assign kill   = h_wr & ~wdata[7];
   assign ctrl   = {8'h00, start, irq_en, 3'b000, cascade, presc};

   always_ff @(posedge clock_16) begin
      if (reset) begin
         reload   <= '0;
         cnt      <= '0;
         start    <= 1'b0;
         irq_en   <= 1'b0;
         cascade  <= 1'b0;
         presc    <= 2'b00;
         overflow <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (l_wr) reload <= wdata[CNT_WIDTH-1:0];
         if (h_wr) begin
            start   <= wdata[7];
            irq_en  <= wdata[6];
            cascade <= wdata[2];
            presc   <= wdata[1:0];
         end
         if (h_wr && !start && wdata[7]) cnt <= reload;
         else if (inc && !kill)          cnt <= ovf ? reload : cnt + 1'b1;
         overflow <= ovf;
         irq      <= ovf & irq_en;
      end
   end
endmodule

module timer_bank #(
   parameter int NUM_TIMERS = 4,
   parameter int CNT_WIDTH  = 16,
   parameter int DIV1_LOG2  = 6,
   parameter int DIV2_LOG2  = 8,
   parameter int DIV3_LOG2  = 10
) (
   input  logic                            clock_16,
   input  logic                            reset,
   input  logic [NUM_TIMERS-1:0]           cnt_l_wr,
   input  logic [NUM_TIMERS-1:0]           cnt_h_wr,
   input  logic [15:0]                     wdata,
   output logic [NUM_TIMERS*CNT_WIDTH-1:0] cnt_l_rd,
   output logic [NUM_TIMERS*16-1:0]        cnt_h_rd,
   output logic [NUM_TIMERS-1:0]           overflow,
   output logic [NUM_TIMERS-1:0]           irq
);
   logic [DIV3_LOG2-1:0]        div;
   logic [3:0]                  tick;
   logic [NUM_TIMERS-1:0]       start, cascade, at_max, kill, inc, ovf;
   logic [NUM_TIMERS-1:0][1:0]  presc;

   always_ff @(posedge clock_16) begin
      if (reset) div <= '0;
      else       div <= div + 1'b1;
   end

   assign tick = {&div[DIV3_LOG2-1:0], &div[DIV2_LOG2-1:0], &div[DIV1_LOG2-1:0], 1'b1};

   // cascade chain ripples combinationally from channel 0 upward
   always_comb begin
      logic prev, en;
      prev = 1'b0;
      en   = 1'b0;
      inc  = '0;
      ovf  = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         en     = ((i != 0) && cascade[i]) ? prev : tick[presc[i]];
         inc[i] = start[i] & en;
         ovf[i] = inc[i] & at_max[i] & ~kill[i];
         prev   = ovf[i];
      end
   end

   for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_lane
      timer_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
         .clock_16 (clock_16),
         .reset    (reset),
         .l_wr     (cnt_l_wr[i]),
         .h_wr     (cnt_h_wr[i]),
         .wdata    (wdata),
         .inc      (inc[i]),
         .ovf      (ovf[i]),
         .cnt      (cnt_l_rd[i*CNT_WIDTH +: CNT_WIDTH]),
         .ctrl     (cnt_h_rd[i*16 +: 16]),
         .start    (start[i]),
         .cascade  (cascade[i]),
         .presc    (presc[i]),
         .at_max   (at_max[i]),
         .kill     (kill[i]),
         .overflow (overflow[i]),
         .irq      (irq[i])
      );
   end
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised bank of NUM_TIMERS GBA-style 16-bit reload timers (TM0..TM3 by default).
- Each channel has a reload value (TMxCNT_L write), a control register (TMxCNT_H), a prescaler select, count-up cascade from the previous channel, and an overflow IRQ.
- All timing runs in the single clock_16 domain. Prescaled rates are clock enables from one shared free-running divider, not derived clocks.
- Sits between the IO register file (writes/reads) and the interrupt controller (irq pulses).

Parameters:
NUM_TIMERS, 4, number of channels; channel i>0 may cascade from channel i-1
CNT_WIDTH, 16, counter and reload width
DIV1_LOG2, 6, log2 of prescaler setting 1 (64 cycles)
DIV2_LOG2, 8, log2 of prescaler setting 2 (256 cycles)
DIV3_LOG2, 10, log2 of prescaler setting 3 (1024 cycles); also the divider width

Ports:
clock_16  in  1  system clock (16.78 MHz)
reset  in  1  synchronous, active-high reset
cnt_l_wr  in  NUM_TIMERS  per-channel write strobe, reload register
cnt_h_wr  in  NUM_TIMERS  per-channel write strobe, control register
wdata  in  16  write data shared by all strobes (low CNT_WIDTH bits used for reload)
cnt_l_rd  out  NUM_TIMERS*CNT_WIDTH  live counter values, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
cnt_h_rd  out  NUM_TIMERS*16  control readback, channel i at [i*16 +: 16]
overflow  out  NUM_TIMERS  registered one-cycle pulse per overflow
irq  out  NUM_TIMERS  registered one-cycle pulse per overflow when irq_en=1

Behaviour:
- Reset (sync): divider=0; every counter, reload, control, overflow, irq = 0.
- Control fields: bit7 start, bit6 irq_en, bit2 cascade, bits1:0 prescaler. Other bits are not stored and read as 0.
- Divider: free-running DIV3_LOG2-bit up-counter, never stopped except by reset.
  - tick[0]=1 every cycle.
  - tick[k] = (divider[DIVk_LOG2-1:0] == all ones), one cycle in 2^DIVk_LOG2.
- Reload write (cnt_l_wr[i]): updates reload only. The counter is unaffected.
- Control write with start 0->1: counter <= reload at that clock edge; channel is running from the next edge. The first increment is at edge+1 at the earliest, gated by its enable.
- Control write with start 1->1: fields update; no reload.
- Control write with start ->0: counter holds its current value (readable); no overflow or irq.
- Increment enable inc[i] = start & (cascade & i>0 ? ovf_evt[i-1] : tick[prescaler]). Cascade on channel 0 is stored but ignored; channel 0 uses the prescaler.
- ovf_evt[i] = inc[i] & (counter == all ones). This is combinational, so a cascade chain ripples within one cycle.
- On inc[i]:
  - if ovf_evt[i]: counter <= reload (the value held before any same-cycle reload write).
  - otherwise: counter <= counter+1.
- overflow[i] <= ovf_evt[i]; irq[i] <= ovf_evt[i] & irq_en. Both are high for exactly one cycle after the overflow edge.
- Reload = all ones: counter stays at all ones and overflows on every enabled increment.
- Simultaneous reload write and overflow: overflow loads the old reload; the new value applies to later overflows and restarts.
- Simultaneous control write (start 1->0) and overflow: the write wins. No reload, no overflow, no irq.
- Reset asserted mid-count: all state cleared at that edge. Outputs are 0 the cycle after.

Test Plan:
- Reload ch0=0xFFFE, control ch0=0x00C0 (start, irq_en, presc0) at edge t -> cnt_l_rd[0]: t+1=0xFFFE, t+2=0xFFFF, t+3=0xFFFE; overflow[0] and irq[0] high only in cycle t+3..t+4; repeats every 2 cycles.
- Reload ch1=0x0000, control=0x0081 (presc 64) -> counter advances only on divider[5:0]==63 edges; exactly 5 increments over 320 cycles; irq[1] never asserts.
- Cascade: ch0 reload 0xFFFF presc0 start; ch1 reload 0xFFF0 control 0x00C4 -> ch1 increments once per ch0 overflow; irq[1] pulses every 16 cycles, in the same cycle as an overflow[0] pulse.
- Stop/restart: run ch2 to 0x0123, write control 0x0000 -> counter holds 0x0123 for 100 cycles; write 0x0080 -> counter = reload next cycle.
- Edge cases: reload write 0x8000 in the same cycle ch0 overflows with old reload 0xFFFE -> counter=0xFFFE, and the next overflow loads 0x8000. Separately, a start 1->0 write in an overflow cycle -> no irq.
- Assert reset mid-cascade with irq pending -> next cycle all counters, cnt_h_rd, overflow and irq are 0, and the divider restarts from 0.
